// File: rtl/instr_reg_arbiter_if.sv
// Bus between the two instruction requesters, the instruction register and
// its consumer. The slave modport is the arbiter's view; the master modport
// is the view of the surrounding environment that drives requests and reads.
interface instr_reg_arbiter_if #(
  parameter int OPC_W = 4,
  parameter int OP_W  = 32,
  parameter int AW    = 5
);
  logic                   req0;
  logic [OPC_W-1:0]       opc0;
  logic signed [OP_W-1:0] op_a0;
  logic signed [OP_W-1:0] op_b0;
  logic                   gnt0;

  logic                   req1;
  logic [OPC_W-1:0]       opc1;
  logic signed [OP_W-1:0] op_a1;
  logic signed [OP_W-1:0] op_b1;
  logic                   gnt1;

  logic                   load_en;
  logic [AW-1:0]          write_pointer;
  logic [OPC_W-1:0]       opcode;
  logic signed [OP_W-1:0] operand_a;
  logic signed [OP_W-1:0] operand_b;

  logic [AW-1:0]          read_pointer;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [AW:0]            count;
  logic                   full;
  logic                   empty;

  modport slave (
    input  req0, opc0, op_a0, op_b0,
    input  req1, opc1, op_a1, op_b1,
    input  rd_ready,
    output gnt0, gnt1,
    output load_en, write_pointer, opcode, operand_a, operand_b,
    output read_pointer, rd_valid, count, full, empty
  );

  modport master (
    output req0, opc0, op_a0, op_b0,
    output req1, opc1, op_a1, op_b1,
    output rd_ready,
    input  gnt0, gnt1,
    input  load_en, write_pointer, opcode, operand_a, operand_b,
    input  read_pointer, rd_valid, count, full, empty
  );
endinterface

// File: rtl/instr_reg_arbiter.sv
// Front-end controller for the 32-entry instruction register. Two requesters
// share the register's write port under round-robin arbitration, and the
// register is treated as a circular queue drained by one valid/ready consumer.
module instr_reg_arbiter #(
  parameter int OPC_W = 4,
  parameter int OP_W  = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input logic               clk,
  input logic               reset,
  instr_reg_arbiter_if.slave bus
);

  // Which requester wins when both ask in the same cycle.
  typedef enum logic {
    PRI_REQ0 = 1'b0,
    PRI_REQ1 = 1'b1
  } priority_t;

  priority_t     prio;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;

  logic full;
  logic empty;
  logic gnt0;
  logic gnt1;
  logic load;
  logic fire;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign load  = gnt0 | gnt1;
  assign fire  = !empty && bus.rd_ready;

  // Grant decision: nothing while full or in reset, a lone requester always
  // wins, and a tie goes to whoever currently holds priority.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && !full) begin
      if (bus.req0 && bus.req1) begin
        if (prio == PRI_REQ0) gnt0 = 1'b1;
        else                  gnt1 = 1'b1;
      end else if (bus.req0) begin
        gnt0 = 1'b1;
      end else if (bus.req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Steer the granted requester's instruction onto the write port; zeros when idle.
  always_comb begin
    bus.opcode    = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    if (gnt0) begin
      bus.opcode    = bus.opc0;
      bus.operand_a = bus.op_a0;
      bus.operand_b = bus.op_b0;
    end else if (gnt1) begin
      bus.opcode    = bus.opc1;
      bus.operand_a = bus.op_a1;
      bus.operand_b = bus.op_b1;
    end
  end

  // Pointer, occupancy and priority bookkeeping; a simultaneous write and
  // read leave the occupancy untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      prio    <= PRI_REQ0;
    end else begin
      if (load) begin
        wr_ptr <= wr_ptr + AW'(1);
        prio   <= gnt0 ? PRI_REQ1 : PRI_REQ0;
      end
      if (fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (load && !fire) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (fire && !load) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

  assign bus.gnt0          = gnt0;
  assign bus.gnt1          = gnt1;
  assign bus.load_en       = load;
  assign bus.write_pointer = wr_ptr;
  assign bus.read_pointer  = rd_ptr;
  assign bus.rd_valid      = !empty;
  assign bus.count         = count_q;
  assign bus.full          = full;
  assign bus.empty         = empty;

endmodule

// File: tb/tb_instr_reg_arbiter.sv
// Directed bench for instr_reg_arbiter. A small array stands in for the
// instruction register so that entries can be read back at read_pointer.
module tb_instr_reg_arbiter;

  localparam int OPC_W = 4;
  localparam int OP_W  = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  localparam logic [OPC_W-1:0] ADD = 4'h1;
  localparam logic [OPC_W-1:0] SUB = 4'h2;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  instr_reg_arbiter_if #(.OPC_W(OPC_W), .OP_W(OP_W), .AW(AW)) bus ();

  instr_reg_arbiter #(.OPC_W(OPC_W), .OP_W(OP_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in instruction register: captures an entry on every load.
  logic [OPC_W+2*OP_W-1:0] irMem [DEPTH];
  logic [OPC_W+2*OP_W-1:0] instrWord;
  always @(posedge clk) begin
    if (bus.load_en) irMem[bus.write_pointer] <= {bus.opcode, bus.operand_a, bus.operand_b};
  end
  assign instrWord = irMem[bus.read_pointer];

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic rdy);
    bus.req0     = r0;
    bus.req1     = r1;
    bus.rd_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.opc0 = ADD; bus.op_a0 = 32'sd5;   bus.op_b0 = 32'sd3;
    bus.opc1 = SUB; bus.op_a1 = 32'sd200; bus.op_b1 = -32'sd2;
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Requests during reset are never granted.
    checkOutput("rst_gnt0", bus.gnt0, 1'b0);
    checkOutput("rst_load", bus.load_en, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_count", bus.count, 0);
    checkOutput("rst_empty", bus.empty, 1'b1);
    checkOutput("rst_full", bus.full, 1'b0);
    checkOutput("rst_valid", bus.rd_valid, 1'b0);
    checkOutput("rst_wptr", bus.write_pointer, 0);
    checkOutput("rst_rptr", bus.read_pointer, 0);

    // Single write from requester 0.
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("single_gnt0", bus.gnt0, 1'b1);
    checkOutput("single_gnt1", bus.gnt1, 1'b0);
    checkOutput("single_load", bus.load_en, 1'b1);
    checkOutput("single_wptr", bus.write_pointer, 0);
    checkOutput("single_opc", bus.opcode, ADD);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("single_count", bus.count, 1);
    checkOutput("single_valid", bus.rd_valid, 1'b1);
    checkOutput("single_rptr", bus.read_pointer, 0);
    checkOutput("single_word", instrWord, {ADD, 32'sd5, 32'sd3});
    checkOutput("idle_opc", bus.opcode, 0);

    // Contention from a fresh reset: grants alternate starting with 0.
    resetDut();
    bus.op_a0 = 32'sd100;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("cont_gnt0_%0d", i), bus.gnt0, (i % 2 == 0));
      checkOutput($sformatf("cont_gnt1_%0d", i), bus.gnt1, (i % 2 == 1));
      checkOutput($sformatf("cont_wptr_%0d", i), bus.write_pointer, i);
      checkOutput($sformatf("cont_opa_%0d", i), bus.operand_a,
                  (i % 2 == 0) ? 72'd100 : 72'd200);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("cont_count", bus.count, 4);
    checkOutput("cont_word1", instrWord, {ADD, 32'sd100, 32'sd3});

    // Fill the remaining 28 slots from requester 0.
    for (int i = 4; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (bus.gnt0 !== 1'b1) checkOutput($sformatf("fill_gnt_%0d", i), bus.gnt0, 1'b1);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("full_flag", bus.full, 1'b1);
    checkOutput("full_count", bus.count, 32);
    checkOutput("full_nogrant", bus.gnt0, 1'b0);
    checkOutput("full_noload", bus.load_en, 1'b0);
    checkOutput("full_wptr_wrap", bus.write_pointer, 0);

    // One read while full: no write this cycle, freed slot granted next cycle.
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("fullrd_noload", bus.load_en, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("afterrd_full", bus.full, 1'b0);
    checkOutput("afterrd_count", bus.count, 31);
    checkOutput("afterrd_gnt0", bus.gnt0, 1'b1);
    checkOutput("afterrd_wptr", bus.write_pointer, 0);
    checkOutput("afterrd_rptr", bus.read_pointer, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("refill_count", bus.count, 32);

    // Concurrent write and read with five entries occupied.
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("conc_count_pre", bus.count, 5);
    checkOutput("conc_gnt1", bus.gnt1, 1'b1);
    checkOutput("conc_wptr_pre", bus.write_pointer, 5);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("conc_count", bus.count, 5);
    checkOutput("conc_wptr", bus.write_pointer, 6);
    checkOutput("conc_rptr", bus.read_pointer, 1);

    // Reading an empty queue changes nothing.
    resetDut();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("empty_valid_%0d", i), bus.rd_valid, 1'b0);
      checkOutput($sformatf("empty_rptr_%0d", i), bus.read_pointer, 0);
      checkOutput($sformatf("empty_count_%0d", i), bus.count, 0);
      tick();
    end

    // Reset in the middle of traffic with priority held by requester 1.
    resetDut();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("mid_count", bus.count, 7);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("mid_rst_gnt1", bus.gnt1, 1'b0);
    checkOutput("mid_rst_load", bus.load_en, 1'b0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("mid_count_clr", bus.count, 0);
    checkOutput("mid_empty", bus.empty, 1'b1);
    checkOutput("mid_wptr", bus.write_pointer, 0);
    checkOutput("mid_rptr", bus.read_pointer, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("mid_prio_gnt0", bus.gnt0, 1'b1);
    checkOutput("mid_prio_gnt1", bus.gnt1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_reg_arbiter.md
Name: instr_reg_arbiter

Overview:
- Controller sitting in front of the 32-entry instruction register.
- Shares the register's write port between two instruction requesters using round-robin arbitration.
- Manages write and read pointers so the register file behaves as a circular instruction queue.
- Sequences read-back to a single consumer with a valid/ready handshake.

Parameters:
- OPC_W, 4: opcode width (matches opcode_t).
- OP_W, 32: operand width, signed.
- DEPTH, 32: instruction register entries; power of two.
- AW, 5: pointer width, log2(DEPTH).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 write request.
- opc0  in  OPC_W  requester 0 opcode.
- op_a0  in  OP_W  requester 0 operand_a.
- op_b0  in  OP_W  requester 0 operand_b.
- gnt0  out  1  requester 0 grant; write accepted this cycle.
- req1, opc1, op_a1, op_b1, gnt1: same as above, for requester 1.
- load_en  out  1  instruction register write enable.
- write_pointer  out  AW  instruction register write address.
- opcode  out  OPC_W  instruction register opcode input.
- operand_a  out  OP_W  instruction register operand_a input.
- operand_b  out  OP_W  instruction register operand_b input.
- read_pointer  out  AW  instruction register read address.
- rd_valid  out  1  entry at read_pointer is valid for the consumer.
- rd_ready  in  1  consumer accepts the entry.
- count  out  AW+1  occupied entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset: on a clock edge with reset=1, the controller clears:
  - wr_ptr=0, rd_ptr=0, count=0;
  - round-robin priority returns to requester 0.
- Grant outputs while reset=1: gnt0=gnt1=0 and load_en=0, combinationally.
- Outputs after reset: write_pointer=0, read_pointer=0, rd_valid=0, full=0, empty=1.
- Instruction register contents are not cleared; stale entries are unreachable because count=0.
- Grant (combinational, same cycle):
  - No grant while full=1 or reset=1.
  - Only one requester asserting: it is granted.
  - Both asserting: the priority holder is granted.
  - Priority flips to the other requester after every grant; it is unchanged on idle cycles.
- At most one gnt per cycle; gnt is one-hot or zero.
- Write path:
  - load_en = gnt0|gnt1.
  - opcode/operand_a/operand_b are muxed from the granted requester; all zero when load_en=0.
  - write_pointer = wr_ptr.
  - The register captures the entry at the edge; wr_ptr increments at that edge, modulo DEPTH.
- Requester protocol: hold req and data until gnt is seen; a deasserted req is never granted.
- Read path:
  - read_pointer = rd_ptr; rd_valid = !empty.
  - The instruction register read is combinational, so the consumer samples instruction_word in the same cycle as rd_valid.
  - Fire = rd_valid & rd_ready; rd_ptr increments on fire, modulo DEPTH.
  - rd_ready while empty has no effect.
- Count:
  - write only: +1; fire only: -1; both together, or neither: unchanged.
  - full and empty are decoded from registered count.
- Latency: an entry written at edge N is readable (rd_valid=1, rd_ptr pointing to it) from cycle N+1.
- Full and read together: no write in a cycle where full=1, even if a fire occurs; the freed slot is grantable from the next cycle.
- Wrap-around: both pointers wrap 31->0 without gaps; count alone distinguishes full from empty when wr_ptr == rd_ptr.
- Reset mid-operation: a pending req is not granted in the reset cycle. Requesters must re-present after reset deasserts.

Test Plan:
- Single write: after reset, req0=1 with opc0=ADD, op_a0=5, op_b0=3.
  -> Same cycle: gnt0=1, load_en=1, write_pointer=0, opcode=ADD.
  -> Next cycle: count=1, rd_valid=1, read_pointer=0.
  -> instruction_word reads back {ADD, 5, 3}.
- Contention: req0 and req1 held for 4 cycles.
  -> Grants go 0,1,0,1 with write_pointer 0,1,2,3; count=4.
- Fill and wrap:
  - 32 writes -> full=1, count=32; req0 held gets no gnt.
  - One fire -> next cycle full=0, gnt0=1, write_pointer=0.
- Concurrent read and write with count=5: write and fire in the same cycle.
  -> count stays 5; wr_ptr and rd_ptr each advance by 1.
- Empty read: rd_ready=1 with count=0 for 3 cycles.
  -> rd_valid=0, read_pointer and count unchanged.
- Reset mid-stream: count=7, priority=1, req1=1, reset pulsed for 1 cycle.
  -> gnt1=0 during reset.
  -> Next cycle: count=0, empty=1, both pointers 0, priority back to requester 0.
